// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the program-counter sequencer.
//   OP_*     3-bit decoded opcodes accepted by pc_sequencer (others are NOP)
//   state_t  2-bit sequencer FSM encoding
package pc_seq_pkg;

    localparam logic [2:0] OP_INC = 3'b000;
    localparam logic [2:0] OP_DEC = 3'b001;
    localparam logic [2:0] OP_JMP = 3'b010;
    localparam logic [2:0] OP_ISZ = 3'b011;
    localparam logic [2:0] OP_STP = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_PULSE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/pc_adder.sv
// pc_adder: combinational PC step with wrap at PC_MAX.
//   p    in  PC_W  current PC (assumed <= PC_MAX)
//   k    in  2     step size (1 or 2)
//   sum  out PC_W  p+k, or p+k-(PC_MAX+1) when p+k passes PC_MAX
//   ovf  out 1     the wrap was taken
module pc_adder
    import pc_seq_pkg::*;
#(
    parameter int PC_W   = 4,
    parameter int PC_MAX = (1 << PC_W) - 1
) (
    input  logic [PC_W-1:0] p,
    input  logic [1:0]      k,
    output logic [PC_W-1:0] sum,
    output logic            ovf
);

    localparam logic [PC_W:0]   MAX_X = (PC_W+1)'(PC_MAX);
    // PC_MAX+1 modulo 2^PC_W; the wrapped result always fits in PC_W bits,
    // so modular subtraction gives the exact value even when SPAN is 0.
    localparam logic [PC_W-1:0] SPAN  = PC_W'(PC_MAX + 1);

    logic [PC_W:0] raw;

    assign raw = (PC_W+1)'(p) + (PC_W+1)'(k);
    assign ovf = (raw > MAX_X);
    assign sum = ovf ? (p + PC_W'(k) - SPAN) : raw[PC_W-1:0];

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer. Accepts one decoded instruction per
// valid/ready transfer and advances the PC; INC/DEC emit a timed mn strobe.
// Optional feature macro: PC_TRAP_EN (wrap or out-of-range JMP halts with trap).
//   clk, rst      clock; asynchronous active-high reset
//   instr_valid   opcode/target/reg_zero valid
//   instr_ready   sequencer idle and able to accept
//   opcode        000 INC, 001 DEC, 010 JMP, 011 ISZ, 100 STP, else NOP
//   target        JMP destination
//   reg_zero      selected register is zero (sampled on accept)
//   pc            current program counter
//   mn, mn_dec    register-modify strobe and its direction (1 = decrement)
//   halted        sequencer stopped until reset
//   trap          illegal PC event (constant 0 without PC_TRAP_EN)
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W   = 4,
    parameter int PC_MAX = (1 << PC_W) - 1,
    parameter int MN_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [2:0]      opcode,
    input  logic [PC_W-1:0] target,
    input  logic            reg_zero,
    output logic [PC_W-1:0] pc,
    output logic            mn,
    output logic            mn_dec,
    output logic            halted,
    output logic            trap
);

    localparam int            CNT_W   = $clog2(MN_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(MN_CYC);
    localparam logic [PC_W:0]    MAX_X   = (PC_W+1)'(PC_MAX);

    state_t            state_q, state_n;
    logic              armed_q;
    logic [PC_W-1:0]   pc_q, pc_n;
    logic              mn_q, mn_n;
    logic              mn_dec_q, mn_dec_n;
    logic              halted_q, halted_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [2:0]        op_q;
    logic [PC_W-1:0]   tgt_q;
    logic              zero_q;

    logic              accept;
    logic              do_commit;
    logic [1:0]        add_k;
    logic [PC_W-1:0]   add_sum;
    logic              add_ovf;
    logic              tgt_bad;
    logic [PC_W-1:0]   new_pc;

    // armed_q keeps instr_ready low until the first edge after reset release.
    assign instr_ready = armed_q && (state_q == S_IDLE);
    assign accept      = instr_valid && instr_ready;

    // Only ISZ with a zero register skips; every other adder use is +1.
    assign add_k = (op_q == OP_ISZ && zero_q) ? 2'd2 : 2'd1;

    pc_adder #(.PC_W(PC_W), .PC_MAX(PC_MAX)) u_add (
        .p   (pc_q),
        .k   (add_k),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign tgt_bad = ({1'b0, tgt_q} > MAX_X);
    assign new_pc  = (op_q == OP_JMP) ? (tgt_bad ? '0 : tgt_q) : add_sum;

`ifdef PC_TRAP_EN
    logic trap_q, trap_n;
    logic fault;
    assign fault = (op_q == OP_JMP) ? tgt_bad : add_ovf;
    assign trap  = trap_q;
`else
    logic unused_ovf;
    assign unused_ovf = add_ovf;
    assign trap       = 1'b0;
`endif

    always_comb begin
        state_n   = state_q;
        pc_n      = pc_q;
        mn_n      = mn_q;
        mn_dec_n  = mn_dec_q;
        halted_n  = halted_q;
        cnt_n     = cnt_q;
        do_commit = 1'b0;
`ifdef PC_TRAP_EN
        trap_n    = trap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (opcode)
                        OP_INC, OP_DEC: begin
                            state_n  = S_PULSE;
                            mn_n     = 1'b1;
                            mn_dec_n = (opcode == OP_DEC);
                            cnt_n    = CNT_W'(1);
                        end
                        OP_STP: begin
                            state_n  = S_HALT;
                            halted_n = 1'b1;
                        end
                        default: state_n = S_EXEC;
                    endcase
                end
            end
            S_PULSE: begin
                // cnt_q counts strobe cycles already elapsed since acceptance.
                if (cnt_q == CNT_END) begin
                    mn_n      = 1'b0;
                    do_commit = 1'b1;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            S_EXEC:  do_commit = 1'b1;
            default: ;
        endcase

        if (do_commit) begin
`ifdef PC_TRAP_EN
            if (fault) begin
                state_n  = S_HALT;
                halted_n = 1'b1;
                trap_n   = 1'b1;
            end else begin
                state_n = S_IDLE;
                pc_n    = new_pc;
            end
`else
            state_n = S_IDLE;
            pc_n    = new_pc;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            armed_q  <= 1'b0;
            pc_q     <= '0;
            mn_q     <= 1'b0;
            mn_dec_q <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
`ifdef PC_TRAP_EN
            trap_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_n;
            armed_q  <= 1'b1;
            pc_q     <= pc_n;
            mn_q     <= mn_n;
            mn_dec_q <= mn_dec_n;
            halted_q <= halted_n;
            cnt_q    <= cnt_n;
`ifdef PC_TRAP_EN
            trap_q   <= trap_n;
`endif
        end
    end

    // Instruction fields are captured on acceptance so the source may move on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            tgt_q  <= '0;
            zero_q <= 1'b0;
        end else if (accept) begin
            op_q   <= opcode;
            tgt_q  <= target;
            zero_q <= reg_zero;
        end
    end

    assign pc     = pc_q;
    assign mn     = mn_q;
    assign mn_dec = mn_dec_q;
    assign halted = halted_q;

endmodule
